ising_run_ctrl: RTL and testbench

// Sequences one anneal run of the coupled_cell oscillator array: arbitrates AXI weight writes vs. runs,

---
 rtl/ising_run_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_ising_run_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ising_run_ctrl.sv
// ============================================================================
//  Module      : ising_run_ctrl
//  Description : Sequences one anneal run of the coupled-cell oscillator
//                array. It arbitrates weight writes against run starts,
//                holds the oscillators in reset while the weights settle and
//                releases them for a programmed number of cycles. It then
//                majority-samples each spin's phase against spin 0 and
//                reports the result.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ising_run_ctrl #(
    parameter int N           = 8,
    parameter int ADDR_W      = 8,
    parameter int HOLD_CYCLES = 16,
    parameter int SAMPLE_LOG2 = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              axi_rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_vh,
    input  logic [31:0]       wr_data,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [31:0]       run_cycles,
    input  logic              abort,
    input  logic [N-1:0]      phase_in,
    output logic              ising_rstn,
    output logic              wready,
    output logic [ADDR_W-1:0] w_addr,
    output logic              w_vh,
    output logic [31:0]       w_data,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [N-1:0]      spin
);

    localparam int c_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int c_CNT_W  = SAMPLE_LOG2 + 1;
    localparam logic [c_CNT_W-1:0] c_HALF = c_CNT_W'(1 << (SAMPLE_LOG2 - 1));

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HOLD   = 3'd1,
        S_RUN    = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                  r_state;
    logic [c_HOLD_W-1:0]     r_hold_cnt;
    logic [31:0]             r_run_cnt;
    logic [SAMPLE_LOG2-1:0]  r_smp_cnt;
    logic [N-1:0]            r_sync [SYNC_STAGES];
    logic [c_CNT_W-1:0]      r_cnt  [N];

    logic                    w_idle;
    logic                    w_wr_acc;
    logic                    w_st_acc;
    logic [N-1:0]            w_ph;
    logic [N-1:0]            w_mis;
    logic [N-1:0]            w_spin_new;

    // Handshakes: writes win over starts; both are only taken in IDLE and
    // never while reset is asserted.
    assign w_idle      = (r_state == S_IDLE);
    assign wr_ready    = w_idle & ~axi_rst;
    assign start_ready = wr_ready & ~wr_valid;
    assign w_wr_acc    = wr_valid & wr_ready;
    assign w_st_acc    = start_valid & start_ready;

    // Phase synchronizer chain; nothing else samples phase_in directly.
    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
            r_sync[0] <= phase_in;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    assign w_ph  = r_sync[SYNC_STAGES-1];
    assign w_mis = w_ph ^ {N{w_ph[0]}};

    // Per-spin mismatch counters, live only in SAMPLE and zero elsewhere so
    // each window starts from a clean count.
    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            for (int i = 0; i < N; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (r_state == S_SAMPLE) r_cnt[i] <= r_cnt[i] + c_CNT_W'(w_mis[i]);
                else                     r_cnt[i] <= '0;
            end
        end
    end

    // Majority vote including the final SAMPLE cycle's mismatch; ties go to 0.
    always_comb begin
        w_spin_new = '0;
        for (int i = 1; i < N; i++) begin
            w_spin_new[i] = ((r_cnt[i] + c_CNT_W'(w_mis[i])) > c_HALF);
        end
    end

    // Run sequencer with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= '0;
            r_run_cnt  <= '0;
            r_smp_cnt  <= '0;
            ising_rstn <= 1'b0;
            wready     <= 1'b0;
            w_addr     <= '0;
            w_vh       <= 1'b0;
            w_data     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            spin       <= '0;
        end else begin
            wready  <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_wr_acc) begin
                        wready <= 1'b1;
                        w_addr <= wr_addr;
                        w_vh   <= wr_vh;
                        w_data <= wr_data;
                    end else if (w_st_acc) begin
                        r_run_cnt  <= run_cycles;
                        r_hold_cnt <= c_HOLD_W'(HOLD_CYCLES - 1);
                        r_state    <= S_HOLD;
                        busy       <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (abort) begin
                        r_state    <= S_IDLE;
                        ising_rstn <= 1'b0;
                        busy       <= 1'b0;
                        aborted    <= 1'b1;
                    end else if (r_hold_cnt == '0) begin
                        ising_rstn <= 1'b1;
                        r_smp_cnt  <= '0;
                        // A zero-length run goes straight to sampling.
                        r_state    <= (r_run_cnt == 32'd0) ? S_SAMPLE : S_RUN;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state    <= S_IDLE;
                        ising_rstn <= 1'b0;
                        busy       <= 1'b0;
                        aborted    <= 1'b1;
                    end else if (r_run_cnt == 32'd1) begin
                        r_smp_cnt <= '0;
                        r_state   <= S_SAMPLE;
                    end else begin
                        r_run_cnt <= r_run_cnt - 32'd1;
                    end
                end
                S_SAMPLE: begin
                    if (abort) begin
                        r_state    <= S_IDLE;
                        ising_rstn <= 1'b0;
                        busy       <= 1'b0;
                        aborted    <= 1'b1;
                    end else if (&r_smp_cnt) begin
                        r_state    <= S_DONE;
                        ising_rstn <= 1'b0;
                        done       <= 1'b1;
                        spin       <= w_spin_new;
                    end else begin
                        r_smp_cnt <= r_smp_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    ising_rstn <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ising_run_ctrl.sv
// ============================================================================
//  Module      : tb_ising_run_ctrl
//  Description : Self-checking bench for ising_run_ctrl. It runs random and
//                directed runs against a cycle-position reference model of
//                the run timeline and of the majority vote.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ising_run_ctrl;

    localparam int N      = 8;
    localparam int ADDR_W = 8;
    localparam int H      = 16;
    localparam int SL     = 4;
    localparam int SS     = 2;
    localparam int S      = 1 << SL;

    logic              clk = 1'b0;
    logic              axi_rst;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_vh;
    logic [31:0]       wr_data;
    logic              start_valid;
    logic              start_ready;
    logic [31:0]       run_cycles;
    logic              abort;
    logic [N-1:0]      phase_in;
    logic              ising_rstn;
    logic              wready;
    logic [ADDR_W-1:0] w_addr;
    logic              w_vh;
    logic [31:0]       w_data;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [N-1:0]      spin;

    always #5 clk = ~clk;

    ising_run_ctrl #(
        .N(N), .ADDR_W(ADDR_W), .HOLD_CYCLES(H), .SAMPLE_LOG2(SL), .SYNC_STAGES(SS)
    ) u_dut (
        .clk(clk), .axi_rst(axi_rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_vh(wr_vh), .wr_data(wr_data),
        .start_valid(start_valid), .start_ready(start_ready), .run_cycles(run_cycles),
        .abort(abort), .phase_in(phase_in), .ising_rstn(ising_rstn),
        .wready(wready), .w_addr(w_addr), .w_vh(w_vh), .w_data(w_data),
        .busy(busy), .done(done), .aborted(aborted), .spin(spin)
    );

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [N-1:0] prev_spin;
    logic [N-1:0] ph [S];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Phase vector seen by SAMPLE cycle j; anything outside the window is noise.
    task automatic drive_phase(input int j);
        if (j >= 0 && j < S) phase_in = ph[j];
        else                 phase_in = N'($urandom);
    endtask

    // Mode 0: random mismatch counts; 1: directed pattern; 2: vote boundaries.
    task automatic make_phases(input int mode);
        int m   [N];
        int off [N];
        for (int i = 0; i < N; i++) begin
            m[i]   = $urandom_range(0, S);
            off[i] = $urandom_range(0, S - 1);
            if (mode == 1) begin
                off[i] = 0;
                case (i)
                    2:       m[i] = S;
                    3:       m[i] = 9;
                    default: m[i] = 0;
                endcase
            end else if (mode == 2) begin
                case (i % 4)
                    1:       m[i] = S / 2;
                    2:       m[i] = S / 2 + 1;
                    3:       m[i] = S;
                    default: m[i] = 0;
                endcase
            end
        end
        for (int j = 0; j < S; j++) begin
            ph[j][0] = 1'($urandom);
            for (int i = 1; i < N; i++) begin
                ph[j][i] = ph[j][0] ^ (((j + off[i]) % S) < m[i]);
            end
        end
    endtask

    // Majority of mismatches against spin 0 over the window; ties give 0.
    function automatic logic [N-1:0] ref_spin();
        logic [N-1:0] s;
        s = '0;
        for (int i = 1; i < N; i++) begin
            int c;
            c = 0;
            for (int j = 0; j < S; j++) if (ph[j][i] != ph[j][0]) c++;
            s[i] = (c > S / 2);
        end
        return s;
    endfunction

    task automatic write_pair(input logic [ADDR_W-1:0] a1, input logic v1, input logic [31:0] d1,
                              input logic [ADDR_W-1:0] a2, input logic v2, input logic [31:0] d2);
        wr_valid = 1'b1; wr_addr = a1; wr_vh = v1; wr_data = d1;
        tick();
        chk("wr1_wready", 32'(wready), 32'd1);
        chk("wr1_addr",   32'(w_addr), 32'(a1));
        chk("wr1_vh",     32'(w_vh),   32'(v1));
        chk("wr1_data",   w_data,      d1);
        wr_addr = a2; wr_vh = v2; wr_data = d2;
        tick();
        wr_valid = 1'b0;
        chk("wr2_wready", 32'(wready), 32'd1);
        chk("wr2_addr",   32'(w_addr), 32'(a2));
        chk("wr2_vh",     32'(w_vh),   32'(v2));
        chk("wr2_data",   w_data,      d2);
        tick();
        chk("wr_wready_low", 32'(wready), 32'd0);
    endtask

    // One run: ka = cycle offset of abort (-1 none), kr = offset of reset (-1 none).
    task automatic do_run(input int R, input int ka, input int kr, input bit with_wr, input int mode);
        int           D;
        int           base;
        bit           ab;
        logic [N-1:0] exp_spin;
        logic [ADDR_W-1:0] ea;
        logic              ev;
        logic [31:0]       ed;
        D    = H + R + S + 1;
        base = H + R + 1;
        ab   = (ka >= 1 && ka < D);
        make_phases(mode);
        exp_spin = ref_spin();
        if (with_wr) begin
            ea = ADDR_W'($urandom); ev = 1'($urandom); ed = $urandom;
            wr_valid = 1'b1; wr_addr = ea; wr_vh = ev; wr_data = ed;
            start_valid = 1'b1; run_cycles = R;
            drive_phase(-100);
            #1;
            chk("both_start_ready", 32'(start_ready), 32'd0);
            chk("both_wr_ready",    32'(wr_ready),    32'd1);
            tick();
            wr_valid = 1'b0;
            chk("both_wready", 32'(wready), 32'd1);
            chk("both_waddr",  32'(w_addr), 32'(ea));
            chk("both_wvh",    32'(w_vh),   32'(ev));
            chk("both_wdata",  w_data,      ed);
        end
        start_valid = 1'b1; run_cycles = R;
        drive_phase(SS - base);
        #1;
        chk("start_ready", 32'(start_ready), 32'd1);
        tick();
        start_valid = 1'b0;
        run_cycles  = $urandom;
        for (int k = 1; k <= D + 1; k++) begin
            if (k == kr) begin
                axi_rst = 1'b1;
                #1;
                chk("rst_rstn",    32'(ising_rstn), 32'd0);
                chk("rst_busy",    32'(busy),       32'd0);
                chk("rst_done",    32'(done),       32'd0);
                chk("rst_aborted", 32'(aborted),    32'd0);
                chk("rst_wready",  32'(wready),     32'd0);
                chk("rst_spin",    32'(spin),       32'd0);
                chk("rst_waddr",   32'(w_addr),     32'd0);
                chk("rst_wdata",   w_data,          32'd0);
                chk("rst_wr_ready", 32'(wr_ready),  32'd0);
                tick();
                axi_rst = 1'b0;
                #1;
                chk("postrst_wr_ready", 32'(wr_ready), 32'd1);
                chk("postrst_busy",     32'(busy),     32'd0);
                prev_spin = '0;
                tick();
                return;
            end
            if (ab && k == ka + 1) begin
                abort = 1'b0;
                chk("ab_aborted",  32'(aborted),    32'd1);
                chk("ab_done",     32'(done),       32'd0);
                chk("ab_busy",     32'(busy),       32'd0);
                chk("ab_rstn",     32'(ising_rstn), 32'd0);
                chk("ab_spin",     32'(spin),       32'(prev_spin));
                chk("ab_wr_ready", 32'(wr_ready),   32'd1);
                tick();
                chk("ab_pulse_end", 32'(aborted), 32'd0);
                return;
            end
            chk("busy",    32'(busy),       32'(k <= D));
            chk("rstn",    32'(ising_rstn), 32'(k > H && k <= D - 1));
            chk("done",    32'(done),       32'(k == D));
            chk("aborted", 32'(aborted),    32'd0);
            if (k == 1) begin
                chk("run_wr_ready",    32'(wr_ready),    32'd0);
                chk("run_start_ready", 32'(start_ready), 32'd0);
            end
            if (k == base) chk("spin_hold", 32'(spin), 32'(prev_spin));
            if (k == D) begin
                chk("spin", 32'(spin), 32'(exp_spin));
                prev_spin = exp_spin;
            end
            if (k == D + 1) chk("idle_wr_ready", 32'(wr_ready), 32'd1);
            abort = (k == ka);
            drive_phase(k + SS - base);
            if (k <= D) tick();
        end
        abort = 1'b0;
        tick();
    endtask

    initial begin
        int R;
        int D;
        int ka;
        axi_rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_vh = 1'b0; wr_data = '0;
        start_valid = 1'b0; run_cycles = '0; abort = 1'b0; phase_in = '0;
        prev_spin = '0;
        tick();
        tick();
        chk("reset_rstn",     32'(ising_rstn), 32'd0);
        chk("reset_busy",     32'(busy),       32'd0);
        chk("reset_spin",     32'(spin),       32'd0);
        chk("reset_wready",   32'(wready),     32'd0);
        chk("reset_wr_ready", 32'(wr_ready),   32'd0);
        axi_rst = 1'b0;
        #1;
        chk("idle_wr_ready0",    32'(wr_ready),    32'd1);
        chk("idle_start_ready0", 32'(start_ready), 32'd1);
        tick();

        write_pair(8'd3, 1'b1, 32'd6, 8'd4, 1'b0, 32'd2);

        do_run(100, -1, -1, 1'b1, 1);
        do_run(0,   -1, -1, 1'b0, 2);
        do_run(20,  H + 20 + 5, -1, 1'b0, 0);
        do_run(10,  3, -1, 1'b0, 0);
        do_run(10,  H + 4, -1, 1'b0, 0);
        do_run(5,   H + 5 + S + 1, -1, 1'b0, 2);
        do_run(1,   -1, -1, 1'b0, 0);

        for (int r = 0; r < 12; r++) begin
            R  = $urandom_range(0, 40);
            D  = H + R + S + 1;
            ka = ($urandom_range(0, 3) == 0) ? $urandom_range(1, D) : -1;
            do_run(R, ka, -1, 1'($urandom), 0);
        end

        do_run(1000, -1, H + 500, 1'b0, 0);
        do_run(3, -1, -1, 1'b0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire
